// File: rtl/fifo_unpack_pkg.sv
// Shared definitions for the FIFO read-side byte unpacker: byte width,
// word geometry helpers and the output FSM state encoding.
package fifo_unpack_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of bytes carried by one FIFO read word.
    function automatic int unsigned word_bytes(input int unsigned word_width);
        return word_width / BYTE_W;
    endfunction

    // Width of the byte index inside a word (at least one bit).
    function automatic int unsigned byte_idx_width(input int unsigned word_width);
        return (word_bytes(word_width) > 2) ? $clog2(word_bytes(word_width)) : 1;
    endfunction

endpackage

// File: rtl/fifo_unpack_wordbuf.sv
// Two-entry word queue between the FIFO read port and the byte shifter.
// Push and pop may happen in the same cycle; the caller guarantees no
// push while full and no pop while empty.
module fifo_unpack_wordbuf #(
    parameter int unsigned WORD_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [WORD_WIDTH-1:0] head_o,
    output logic [1:0]            count_o
);

    logic [WORD_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // Storage, pointers and occupancy; everything cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_byte_unpacker.sv
// Read-side companion of the 8-bit-in / 64-bit-out async FIFO. Pops words,
// hides the FIFO read latency with a 2-word buffer and serialises each word
// onto a valid/ready byte stream at up to one byte per cycle.
// Build option: define UNPACK_MSB_FIRST_EN to emit the most significant
// byte of each word first; otherwise byte [7:0] goes out first.
module fifo_byte_unpacker
    import fifo_unpack_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic [WORD_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic [BYTE_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  byte_cnt,
    output logic                  busy
);

    localparam int unsigned NBYTES = word_bytes(WORD_WIDTH);
    localparam int unsigned IDX_W  = byte_idx_width(WORD_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t                state_q, state_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [2:0]            infl;
    logic                  cap;
    logic [1:0]            buf_cnt;
    logic [WORD_WIDTH-1:0] buf_head;
    logic                  buf_push, buf_pop;
    logic                  avail, accept, last_acc, load;
    logic [WORD_WIDTH-1:0] next_word;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BYTE_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // Pop strobe delay line and count of words still in flight from the FIFO.
    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = fifo_rd_en;
        infl      = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            infl = infl + {2'b00, pipe_q[i]};
        end
    end

    assign cap = pipe_q[RD_LATENCY-1];

    // Pop only while buffer plus in-flight words leave room; never during reset.
    assign fifo_rd_en = !rd_rst && !fifo_rd_empty && (({1'b0, buf_cnt} + infl) < 3'd2);

    // Pop strobe pipeline register.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    fifo_unpack_wordbuf #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_wordbuf (
        .clk_i  (rd_clk),
        .rst_i  (rd_rst),
        .push_i (buf_push),
        .data_i (fifo_rd_data),
        .pop_i  (buf_pop),
        .head_o (buf_head),
        .count_o(buf_cnt)
    );

    // A word is available from the buffer head or, when the buffer is empty,
    // straight from the FIFO data arriving this cycle (saves one cycle of latency).
    assign avail     = (buf_cnt != 2'd0) || cap;
    assign next_word = (buf_cnt != 2'd0) ? buf_head : fifo_rd_data;
    assign accept    = (state_q == SHIFT) && m_ready;
    assign last_acc  = accept && (idx_q == LAST_IDX);

    // Output FSM state register.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (avail) state_d = SHIFT;
            SHIFT:   if (last_acc && !avail) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output FSM datapath control: word load, buffer handshake, byte stepping.
    // Arriving data bypasses the buffer only when it is loaded straight into
    // the shifter; otherwise it is queued.
    always_comb begin
        load     = avail && ((state_q == IDLE) || last_acc);
        buf_pop  = load && (buf_cnt != 2'd0);
        buf_push = cap && !(load && (buf_cnt == 2'd0));
        shift_d  = shift_q;
        idx_d    = idx_q;
        data_d   = data_q;
        cnt_d    = cnt_q + CNT_WIDTH'(accept);
        if (load) begin
            idx_d = '0;
`ifdef UNPACK_MSB_FIRST_EN
            data_d  = next_word[WORD_WIDTH-1 -: BYTE_WIDTH];
            shift_d = next_word << BYTE_WIDTH;
`else
            data_d  = next_word[BYTE_WIDTH-1:0];
            shift_d = next_word >> BYTE_WIDTH;
`endif
        end else if (accept && !last_acc) begin
            idx_d = idx_q + 1'b1;
`ifdef UNPACK_MSB_FIRST_EN
            data_d  = shift_q[WORD_WIDTH-1 -: BYTE_WIDTH];
            shift_d = shift_q << BYTE_WIDTH;
`else
            data_d  = shift_q[BYTE_WIDTH-1:0];
            shift_d = shift_q >> BYTE_WIDTH;
`endif
        end
    end

    // Shifter, byte index, output byte and delivered-byte counter.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_valid  = (state_q == SHIFT);
    assign m_data   = data_q;
    assign byte_cnt = cnt_q;
    assign busy     = (buf_cnt != 2'd0) || (infl != 3'd0) || m_valid;

endmodule
